// File: rtl/poly_synth_core_if.sv
// Note-event and sample interface for poly_synth_core.
// The master drives note events and wave selection; the slave returns samples and voice flags.
interface poly_synth_core_if #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_BITS = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int NOTE_BITS  = 7
);
    logic                         note_valid_in;
    logic                         note_ready_out;
    logic                         note_on_in;
    logic [NOTE_BITS-1:0]         note_in;
    logic [PHASE_BITS-1:0]        phase_incr_in;
    logic [1:0]                   wave_type_in;
    logic signed [OUT_WIDTH-1:0]  sample_out;
    logic                         sample_valid_out;
    logic [NUM_VOICES-1:0]        active_voices_out;

    modport master (
        output note_valid_in, note_on_in, note_in, phase_incr_in, wave_type_in,
        input  note_ready_out, sample_out, sample_valid_out, active_voices_out
    );

    modport slave (
        input  note_valid_in, note_on_in, note_in, phase_incr_in, wave_type_in,
        output note_ready_out, sample_out, sample_valid_out, active_voices_out
    );
endinterface

// File: rtl/poly_synth_core.sv
// Polyphonic DDS core: NUM_VOICES phase-accumulator voices with free-first / oldest-steal allocation,
// walked one voice per clock on every sample tick. Define MIX_SATURATE_EN to clip the mix instead of shifting.
module poly_synth_core #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_BITS = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int NOTE_BITS  = 7,
    parameter int SAMPLE_DIV = 512
) (
    input  logic               clk_in,
    input  logic               rst_in,
    poly_synth_core_if.slave   bus
);
    localparam int LV   = $clog2(NUM_VOICES);
    localparam int AW   = OUT_WIDTH + LV;
    localparam int CW   = $clog2(SAMPLE_DIV);
    localparam int MAXV = (1 << (OUT_WIDTH - 1)) - 1;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCUM = 2'd1, ST_OUTPUT = 2'd2} state_t;

    state_t                      state_r, state_nxt_s;
    logic [CW-1:0]               cnt_r, cnt_nxt_s;
    logic                        tick_s, ready_r, ready_nxt_s, accept_s, valid_r;
    logic [LV-1:0]               idx_r, chosen_s;
    logic signed [AW-1:0]        acc_r, wave_ext_s;
    logic signed [OUT_WIDTH-1:0] wave_s, out_s, sample_r;
    logic [PHASE_BITS-1:0]       phase_r [NUM_VOICES];
    logic [PHASE_BITS-1:0]       incr_r  [NUM_VOICES];
    logic [NOTE_BITS-1:0]        note_r  [NUM_VOICES];
    logic [LV-1:0]               age_r   [NUM_VOICES];
    logic [NUM_VOICES-1:0]       active_r;

    function automatic logic signed [OUT_WIDTH-1:0] wave_fn(input logic [PHASE_BITS-1:0] phase,
                                                           input logic [1:0] wt);
        logic [OUT_WIDTH-1:0] u;
        logic [OUT_WIDTH-1:0] v;
        u = phase[PHASE_BITS-1 -: OUT_WIDTH];
        v = '0;
        case (wt)
            2'b00:   v = u[OUT_WIDTH-1] ? {1'b1, {(OUT_WIDTH-2){1'b0}}, 1'b1}
                                        : {1'b0, {(OUT_WIDTH-1){1'b1}}};
            2'b01:   v = {~u[OUT_WIDTH-1], u[OUT_WIDTH-2:0]};
            2'b10: begin
                v = u[OUT_WIDTH-1] ? ~(u << 1'b1) : (u << 1'b1);
                v = {~v[OUT_WIDTH-1], v[OUT_WIDTH-2:0]};
            end
            default: v = '0;
        endcase
        return $signed(v);
    endfunction

    assign tick_s      = (cnt_r == CW'(SAMPLE_DIV - 1));
    assign cnt_nxt_s   = tick_s ? '0 : cnt_r + 1'b1;
    assign ready_nxt_s = (state_nxt_s == ST_IDLE) && (cnt_nxt_s != CW'(SAMPLE_DIV - 1));
    assign accept_s    = bus.note_valid_in && ready_r;
    assign wave_s      = active_r[idx_r] ? wave_fn(phase_r[idx_r], bus.wave_type_in) : '0;
    assign wave_ext_s  = AW'(wave_s);

`ifdef MIX_SATURATE_EN
    localparam logic signed [AW-1:0] SAT_MAX = AW'(MAXV);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-MAXV - 1);
    assign out_s = (acc_r > SAT_MAX) ? OUT_WIDTH'(MAXV) :
                   (acc_r < SAT_MIN) ? OUT_WIDTH'(-MAXV - 1) : acc_r[OUT_WIDTH-1:0];
`else
    logic signed [AW-1:0] shr_s;
    assign shr_s = acc_r >>> LV;
    assign out_s = shr_s[OUT_WIDTH-1:0];
`endif

    // Next-state logic for the sample walk
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:   state_nxt_s = tick_s ? ST_ACCUM : ST_IDLE;
            ST_ACCUM:  state_nxt_s = (idx_r == LV'(NUM_VOICES - 1)) ? ST_OUTPUT : ST_ACCUM;
            ST_OUTPUT: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Voice selection for note-on: matching note, else lowest free, else oldest (lowest index on tie)
    always_comb begin
        logic          match_found, free_found, take;
        logic [LV-1:0] match_idx, free_idx, old_idx, old_age;
        match_found = 1'b0;
        free_found  = 1'b0;
        match_idx   = '0;
        free_idx    = '0;
        old_idx     = '0;
        old_age     = '0;
        take        = 1'b0;
        // Scan high to low so the lowest qualifying index is the last one kept
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            take        = active_r[i] && (note_r[i] == bus.note_in);
            match_idx   = take ? LV'(i) : match_idx;
            match_found = match_found | take;
            take        = !active_r[i];
            free_idx    = take ? LV'(i) : free_idx;
            free_found  = free_found | take;
            take        = (age_r[i] >= old_age);
            old_idx     = take ? LV'(i) : old_idx;
            old_age     = take ? age_r[i] : old_age;
        end
        chosen_s = match_found ? match_idx : (free_found ? free_idx : old_idx);
    end

    // FSM state, tick counter, mix accumulator and sample output registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            idx_r    <= '0;
            acc_r    <= '0;
            sample_r <= '0;
            valid_r  <= 1'b0;
            ready_r  <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ready_r <= ready_nxt_s;
            valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    idx_r <= '0;
                    acc_r <= '0;
                end
                ST_ACCUM: begin
                    acc_r <= acc_r + wave_ext_s;
                    idx_r <= idx_r + 1'b1;
                end
                ST_OUTPUT: begin
                    sample_r <= out_s;
                    valid_r  <= 1'b1;
                end
                default: begin
                    idx_r <= '0;
                    acc_r <= '0;
                end
            endcase
        end
    end

    // Per-voice state: phase advance during the walk, note events only while idle
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            active_r <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_r[i] <= '0;
                incr_r[i]  <= '0;
                note_r[i]  <= '0;
                age_r[i]   <= '0;
            end
        end else if (state_r == ST_ACCUM) begin
            phase_r[idx_r] <= active_r[idx_r] ? phase_r[idx_r] + incr_r[idx_r] : phase_r[idx_r];
        end else if (accept_s && bus.note_on_in) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (LV'(i) == chosen_s) begin
                    active_r[i] <= 1'b1;
                    phase_r[i]  <= '0;
                    incr_r[i]   <= bus.phase_incr_in;
                    note_r[i]   <= bus.note_in;
                    age_r[i]    <= '0;
                end else if (active_r[i]) begin
                    age_r[i] <= (age_r[i] == LV'(NUM_VOICES - 1)) ? age_r[i] : age_r[i] + 1'b1;
                end
            end
        end else if (accept_s) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (note_r[i] == bus.note_in) begin
                    active_r[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.note_ready_out    = ready_r;
    assign bus.sample_out        = sample_r;
    assign bus.sample_valid_out  = valid_r;
    assign bus.active_voices_out = active_r;
endmodule

// File: doc/poly_synth_core.md
Name: poly_synth_core

Overview:
- Polyphonic successor to the single-voice synthesizer path. It holds NUM_VOICES DDS voices, each with its own phase accumulator.
- Note-on/note-off events arrive over a valid/ready handshake. Voices are allocated free-first; when none is free, the oldest voice is stolen.
- Once per sample tick, the block walks all voices (one per clock), mixes them, and emits one signed sample with a valid pulse.
- Sits between the keyboard/MIDI front end and the pdm modulator, all on the 98.3 MHz audio clock.

Parameters:
- NUM_VOICES, 4: number of voices; power of two, 2..16.
- PHASE_BITS, 32: width of the phase accumulator and of the increment.
- OUT_WIDTH, 16: width of the signed sample.
- NOTE_BITS, 7: width of the note number.
- SAMPLE_DIV, 512: clk_in cycles per sample tick; must be at least NUM_VOICES+3.

Ports:
- clk_in  in  1  audio clock; the only clock.
- rst_in  in  1  synchronous, active-high reset.
- note_valid_in  in  1  a note event is presented.
- note_ready_out  out  1  block can accept a note event this cycle.
- note_on_in  in  1  1 = note-on, 0 = note-off.
- note_in  in  NOTE_BITS  note number.
- phase_incr_in  in  PHASE_BITS  per-sample increment; used on note-on only.
- wave_type_in  in  2  00 square, 01 saw, 10 triangle, 11 silent; applies to all voices.
- sample_out  out  OUT_WIDTH signed  mixed sample.
- sample_valid_out  out  1  one-cycle pulse when sample_out updates.
- active_voices_out  out  NUM_VOICES  per-voice active flags.

Behaviour:
- Reset: all voices inactive; phase, increment, note and age cleared to 0; tick counter = 0; FSM = IDLE; sample_out = 0; sample_valid_out = 0; active_voices_out = 0.
- Tick counter: free-running 0..SAMPLE_DIV-1, wraps to 0. A tick occurs in any cycle where the count equals SAMPLE_DIV-1.
- FSM: IDLE -> ACCUM on a tick. ACCUM lasts exactly NUM_VOICES cycles, with voice index 0..NUM_VOICES-1 and the accumulator cleared on entry. ACCUM -> OUTPUT (1 cycle) -> IDLE.
- ACCUM, per voice:
  - If active, add wave(phase) to the accumulator, then phase += incr (mod 2^PHASE_BITS).
  - If inactive, add 0; its phase is held.
- Waveform: u = phase[PHASE_BITS-1 -: OUT_WIDTH], M = u MSB, MAX = 2^(OUT_WIDTH-1)-1.
  - Square: M = 0 gives +MAX, otherwise -MAX.
  - Saw: u with its MSB inverted, read as signed.
  - Triangle: v = M ? ~(u<<1) : (u<<1), truncated to OUT_WIDTH, then MSB inverted, read as signed.
  - Silent: 0.
- Accumulator width is OUT_WIDTH + log2(NUM_VOICES), signed.
- OUTPUT: sample_out <= acc >>> log2(NUM_VOICES); sample_valid_out <= 1 for one cycle. For a tick in cycle T, the pulse is visible in cycle T+NUM_VOICES+2; it is 0 in all other cycles.
- note_ready_out = (FSM == IDLE) && no tick this cycle. A note is accepted when valid && ready, and takes effect at that edge.
- Note-on allocation, in priority order:
  - (a) An active voice already holding the same note is retriggered: phase = 0, incr reloaded, age = 0.
  - (b) Otherwise the lowest-index inactive voice is used.
  - (c) Otherwise the active voice with the largest age is stolen, lowest index on a tie.
  - The chosen voice gets active = 1, phase = 0, incr = phase_incr_in, note stored, age = 0.
  - Every other active voice increments its age, saturating at NUM_VOICES-1.
- Note-off: clears active on every voice whose note matches. With no match, there is no state change; the event is still accepted.
- Held-off events: note_valid_in held during ACCUM/OUTPUT waits; the event is accepted in the first IDLE cycle with no tick.
- Reset asserted mid-ACCUM aborts the walk; no sample_valid_out pulse is produced.

Optional Feature:
- Macro: MIX_SATURATE_EN.
- When defined, OUTPUT does no shift; the accumulator is clipped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and that value drives sample_out.
- When undefined, the output is the arithmetic shift by log2(NUM_VOICES), as in Behaviour.

Test Plan:
All scenarios use NUM_VOICES=4, OUT_WIDTH=16, PHASE_BITS=32, SAMPLE_DIV=16, macro undefined unless stated.
- Reset: hold rst_in for 3 cycles. After release, sample_out = 0, active_voices_out = 0, note_ready_out = 1 outside ACCUM/OUTPUT/tick cycles; the first valid pulse arrives 4+2 cycles after the first tick.
- Single square voice: note-on, note 60, incr 0x4000_0000, wave 00. Successive samples are 8191, 8191, -8192, -8192, 8191.
- Stealing: note-ons for notes 60, 61, 62, 63, then 64. Notes land in voices 0..3, then note 64 replaces voice 0. active_voices_out = 4'b1111.
- Retrigger: voice holding note 62, which has advanced phase, gets a repeated note-on 62. No new voice is used; that voice's next contribution is computed from phase 0.
- Note-off: note-off 70 changes nothing. Note-off 61 clears bit 1, and the next sample excludes that voice.
- Saturation: two square voices at phase 0 give 16383 without the macro and 32767 with MIX_SATURATE_EN. note_valid_in held during ACCUM is accepted only after OUTPUT ends.
